sp_ram_ctrl_wrapper: RTL and testbench



---
 rtl/sp_ram_ctrl_wrapper.sv | 136 +++++++++++++
 tb/tb_sp_ram_ctrl_wrapper.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_ctrl_wrapper.sv
// Generic single-port RAM behind a valid/ready request port, with per-byte write
// masking, optional output register and a zero-fill sequencer.
module sp_ram_ctrl_wrapper #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 32,
  parameter int ADDR_WIDTH    = $clog2(DEPTH),
  parameter int OUT_REG       = 0,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  input  logic                    init_start,
  output logic                    init_busy,
  output logic                    init_done
);
  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PENULT_ADDR = ADDR_WIDTH'(DEPTH - 2);

  typedef enum logic {IDLE, INIT} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic                    access;
  logic                    fill;
  logic                    mem_en;
  logic                    rd;
  logic                    ceb;
  logic                    web;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [NB-1:0]           be;
  logic [DATA_WIDTH-1:0]   bweb;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    rd_valid;
  logic [DATA_WIDTH-1:0]   rd_data;

  // Macro-style control: the same enable would drive the ICG on an ASIC build.
  assign access    = req_valid && req_ready;
  assign fill      = (state == INIT);
  assign mem_en    = !rst && (access || fill);
  assign ceb       = !mem_en;
  assign web       = !(fill || req_we);
  assign rd        = !ceb && web;
  assign mem_addr  = fill ? cnt : req_addr;
  assign mem_wdata = fill ? '0 : req_wdata;
  assign be        = fill ? '1 : req_be;

  for (genvar gi = 0; gi < NB; gi++) begin : g_bweb
    assign bweb[gi*8 +: 8] = {8{~be[gi]}};
  end

  always_ff @(posedge clk) begin
    if (!ceb && !web) begin
      for (int b = 0; b < NB; b++) begin
        if (!bweb[b*8]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  // Read register only loads on reads, so rsp_rdata holds between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd;
      if (rd) rd_data <= mem[mem_addr];
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_valid <= 1'b0;
        out_data  <= '0;
      end else begin
        out_valid <= rd_valid;
        if (rd_valid) out_data <= rd_data;
      end
    end
    assign rsp_valid = out_valid;
    assign rsp_rdata = out_data;
  end else begin : g_no_out_reg
    assign rsp_valid = rd_valid;
    assign rsp_rdata = rd_data;
  end

  // init_done is set one cycle early so it is high during the last fill write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= (INIT_ON_RESET != 0) ? INIT : IDLE;
      cnt       <= '0;
      init_busy <= (INIT_ON_RESET != 0);
      req_ready <= (INIT_ON_RESET == 0);
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b0;
      case (state)
        IDLE: begin
          if (init_start) begin
            state     <= INIT;
            init_busy <= 1'b1;
            req_ready <= 1'b0;
          end
        end
        INIT: begin
          if (cnt == PENULT_ADDR) init_done <= 1'b1;
          if (cnt == LAST_ADDR) begin
            cnt       <= '0;
            state     <= IDLE;
            init_busy <= 1'b0;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && access) assert (32'(req_addr) < DEPTH);
  end
endmodule

// File: tb/tb_sp_ram_ctrl_wrapper.sv
// Drives two wrappers (OUT_REG=0 and 1) with identical traffic; a scoreboard
// checks responses and fill/handshake timing against a reference model.
module tb_sp_ram_ctrl_wrapper;
  localparam int DEPTH = 32;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        init_start;
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        init_busy [2];
  logic        init_done [2];

  int          cyc = 0;
  int          fs = 0;
  int          n_pass = 0;
  int          n_checks = 0;
  int          n_txn = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] last_data [2];
  exp_t        q0[$];
  exp_t        q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    sp_ram_ctrl_wrapper #(.DATA_WIDTH(32), .DEPTH(DEPTH), .OUT_REG(gi), .INIT_ON_RESET(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready[gi]),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid[gi]),
      .rsp_rdata (rsp_rdata[gi]),
      .init_start(init_start),
      .init_busy (init_busy[gi]),
      .init_done (init_done[gi])
    );
  end

  task automatic chk(string name, int d, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", name, d, cyc, got, exp);
  endtask

  function automatic bit m_busy(int c);
    return (c >= fs) && (c < fs + DEPTH);
  endfunction

  task automatic zero_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: per-cycle handshake/fill checks and response scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        chk("rst_rsp_valid", d, 32'(rsp_valid[d]), 0);
        chk("rst_rsp_rdata", d, rsp_rdata[d], 0);
        chk("rst_init_busy", d, 32'(init_busy[d]), 1);
        chk("rst_req_ready", d, 32'(req_ready[d]), 0);
        chk("rst_init_done", d, 32'(init_done[d]), 0);
        last_data[d] = '0;
      end
      q0.delete();
      q1.delete();
    end else begin
      for (int d = 0; d < 2; d++) begin
        exp_t e;
        bit   has;
        has = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (has) begin
          if (d == 0) e = q0[0];
          else        e = q1[0];
        end
        chk("init_busy", d, 32'(init_busy[d]), 32'(m_busy(cyc)));
        chk("req_ready", d, 32'(req_ready[d]), 32'(!m_busy(cyc)));
        chk("init_done", d, 32'(init_done[d]), 32'(cyc == fs + DEPTH - 1));
        if (rsp_valid[d]) begin
          if (!has) begin
            chk("spurious_rsp", d, 32'(rsp_valid[d]), 0);
          end else begin
            chk("rsp_data", d, rsp_rdata[d], e.data);
            chk("rsp_cycle", d, 32'(cyc), 32'(e.due));
            last_data[d] = e.data;
            if (d == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
          end
        end else begin
          if (has && e.due <= cyc) begin
            chk("missed_rsp", d, 32'(rsp_valid[d]), 1);
            if (d == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
          end
          chk("rdata_hold", d, rsp_rdata[d], last_data[d]);
        end
      end
    end
  end

  // Present one request; the model decides when it is accepted.
  task automatic issue(bit we, int addr, logic [31:0] wd, logic [3:0] be, bit start);
    int   k;
    exp_t e;
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = 5'(addr);
    req_wdata  = wd;
    req_be     = be;
    init_start = start;
    while (m_busy(cyc)) step();
    k = cyc;
    if (!we) begin
      e.data = model[addr];
      e.due  = k + 1;
      q0.push_back(e);
      e.due  = k + 2;
      q1.push_back(e);
    end else begin
      for (int b = 0; b < 4; b++)
        if (be[b]) model[addr][b*8 +: 8] = wd[b*8 +: 8];
    end
    if (start) begin
      fs = k + 1;
      zero_model();
    end
    n_txn++;
    $display("txn %0d cyc=%0d %s addr=%0d wdata=%h be=%b start=%0b exp=%h",
             n_txn, k, we ? "WR" : "RD", addr, wd, be, start, model[addr]);
    step();
    req_valid  = 1'b0;
    init_start = 1'b0;
  endtask

  task automatic pulse_init();
    init_start = 1'b1;
    if (!m_busy(cyc)) begin
      fs = cyc + 1;
      zero_model();
    end
    $display("init_start cyc=%0d %s", cyc, m_busy(cyc) ? "ignored" : "accepted");
    step();
    init_start = 1'b0;
  endtask

  task automatic do_reset(int hold);
    rst = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    fs = cyc;
    zero_model();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    while (m_busy(cyc)) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_be     = '0;
    init_start = 1'b0;
    #2;
    do_reset(3);
    wait_idle();

    // Fill after reset leaves everything zero.
    for (int a = 0; a < DEPTH; a++) issue(0, a, 0, 0, 0);

    // Byte-masked writes.
    issue(1, 5, 32'hDEADBEEF, 4'b1111, 0);
    issue(1, 5, 32'h11223344, 4'b0101, 0);
    issue(0, 5, 0, 0, 0);
    issue(1, 6, 32'hCAFEF00D, 4'b0000, 0);
    issue(0, 6, 0, 0, 0);

    // Back-to-back reads, then idle so rdata hold is observed.
    issue(1, 0, 32'hA, 4'hF, 0);
    issue(1, 1, 32'hB, 4'hF, 0);
    issue(1, 2, 32'hC, 4'hF, 0);
    issue(0, 0, 0, 0, 0);
    issue(0, 1, 0, 0, 0);
    issue(0, 2, 0, 0, 0);
    repeat (4) step();

    // init_start during a fill is ignored; a request waits for IDLE.
    pulse_init();
    while (cyc < fs + 10) step();
    pulse_init();
    issue(0, 3, 0, 0, 0);
    issue(0, 5, 0, 0, 0);

    // Reset in the middle of a fill restarts it from scratch.
    issue(1, 9, 32'h55AA55AA, 4'hF, 0);
    pulse_init();
    while (cyc < fs + 15) step();
    do_reset(2);
    wait_idle();
    issue(0, 9, 0, 0, 0);

    // Read accepted together with init_start returns pre-fill data.
    issue(1, 7, 32'h12345678, 4'hF, 0);
    issue(0, 7, 0, 0, 1);
    issue(0, 7, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      bit          we;
      bit          st;
      int          addr;
      logic [31:0] wd;
      logic [3:0]  be;
      we   = ($urandom_range(0, 1) == 1);
      st   = ($urandom_range(0, 39) == 0);
      addr = $urandom_range(0, DEPTH - 1);
      wd   = $urandom;
      be   = 4'($urandom_range(0, 15));
      issue(we, addr, wd, be, st);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) step();
    end

    repeat (6) step();
    chk("drain_q", 0, 32'(q0.size()), 0);
    chk("drain_q", 1, 32'(q1.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
